// File: rtl/flag_arbiter.sv
// Two-requester round-robin arbiter in front of one shared zero/equality
// checker pair; one operation in flight, result held until the consumer takes it.

module check_zero32 (
  input  logic [31:0] a,
  output logic        z
);
  assign z = (a == 32'd0);
endmodule

module check_equal32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq
);
  assign eq = (a == b);
endmodule

module flag_arbiter #(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_zero,
  output logic        rsp_equal,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, y_q;
  logic        id_q, zero_q, eq_q, prio_q;
  logic        gnt_id, req_hs, rsp_hs;
  logic        chk_zero, chk_eq;

  // A lone requester wins outright; the pointer only breaks ties.
  assign gnt_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
  // rst_n gates the readies so nothing looks accepted while reset is held.
  assign req_hs = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign rsp_hs = (state_q == RESP) && rsp_ready;

  assign req0_ready = req_hs && !gnt_id;
  assign req1_ready = req_hs &&  gnt_id;

  check_zero32  u_zero (.a(x_q), .z(chk_zero));
  check_equal32 u_eq   (.a(x_q), .b(y_q), .eq(chk_eq));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      id_q    <= 1'b0;
      zero_q  <= 1'b0;
      eq_q    <= 1'b0;
      prio_q  <= PRIO_RESET;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        x_q  <= gnt_id ? req1_x : req0_x;
        y_q  <= gnt_id ? req1_y : req0_y;
        id_q <= gnt_id;
      end
      if (state_q == EVAL) begin
        zero_q <= chk_zero;
        eq_q   <= chk_eq;
      end
      if (rsp_hs) prio_q <= ~id_q;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_zero  = zero_q;
  assign rsp_equal = eq_q;
  assign busy      = (state_q != IDLE);

endmodule
